// File: rtl/mem_arbiter.sv
// mem_arbiter: sequencing controller and two-port arbiter for mainmemory.
// Port 0 is the instruction-fetch reader. Port 1 is the load/store port.
// Memory dump requests always win over both ports.
// Only one memory operation is in flight at a time. Every output is registered.
// Optional build macro MEM_ARB_ROUND_ROBIN_EN: two-port round-robin arbitration
// replaces the default fixed priority, in which port 1 beats port 0.
//
// Handshake: reqN is a level request, held until gntN pulses for one cycle.
// The requester's completion (rvalid0 / done1) follows exactly two cycles after
// gntN. err is coincident with that completion when the address was out of range.
// A request still high after its completion is treated as a new request.
module mem_arbiter #(
  parameter int          MEM_DEPTH = 101,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic [31:0] addr0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [31:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        gnt1,
  output logic        done1,
  output logic [31:0] rdata1,
  output logic        err,
  input  logic        dump_req,
  output logic        dump_done,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  output logic        mem_fwrite,
  input  logic [31:0] mem_rdata
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;
  localparam logic [1:0] S_DUMP   = 2'd3;

  localparam logic [31:0] DEPTH_W = 32'(MEM_DEPTH);

  logic [1:0] state;
  logic       cur_port;    // latched winner: 0 = fetch, 1 = load/store
  logic       cur_we;      // latched store flag for port 1
  logic       cur_oor;     // latched out-of-range flag
  logic       dump_armed;  // dump_req must drop once before the next dump is taken

  logic       oor0;
  logic       oor1;
  logic       can_arb;
  logic       take_dump;
  logic       take0;
  logic       take1;

  // Unsigned 32-bit range checks. Address MEM_DEPTH-1 is the last valid word.
  assign oor0 = (addr0 >= DEPTH_W);
  assign oor1 = (addr1 >= DEPTH_W);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_ptr;  // 1 = port 1 wins the next tie, 0 = port 0 wins it

  // Round-robin pointer: after each grant the other port is favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b1;
    end else if (take1) begin
      rr_ptr <= 1'b0;
    end else if (take0) begin
      rr_ptr <= 1'b1;
    end
  end
`endif

  // Arbitration decision, valid only in IDLE and on the edge leaving RESP.
  always_comb begin
    can_arb   = (state == S_IDLE) || (state == S_RESP);
    take_dump = can_arb && dump_req && dump_armed;
    take0     = 1'b0;
    take1     = 1'b0;
    if (can_arb && !take_dump) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (req0 && req1) begin
        take1 = rr_ptr;
        take0 = !rr_ptr;
      end else begin
        take1 = req1;
        take0 = req0;
      end
`else
      take1 = req1;
      take0 = req0 && !req1;
`endif
    end
  end

  // Dump re-arm: a dump consumes the arm; dump_req low re-arms it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dump_armed <= 1'b1;
    end else if (take_dump) begin
      dump_armed <= 1'b0;
    end else if (!dump_req) begin
      dump_armed <= 1'b1;
    end
  end

  // Main FSM: registered memory strobes, grants, completions and read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cur_port   <= 1'b0;
      cur_we     <= 1'b0;
      cur_oor    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      dump_done  <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_fwrite <= 1'b0;
    end else begin
      // Every pulse output defaults low; only the cases below raise one.
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      dump_done  <= 1'b0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_fwrite <= 1'b0;

      case (state)
        S_ACCESS: begin
          // The memory samples the strobe on this edge.
          state <= S_RESP;
        end
        S_RESP: begin
          // Memory data is now valid; complete the latched access.
          err <= cur_oor;
          if (!cur_port) begin
            rvalid0 <= 1'b1;
            rdata0  <= cur_oor ? ERR_DATA : mem_rdata;
          end else begin
            done1 <= 1'b1;
            if (!cur_we) begin
              rdata1 <= cur_oor ? ERR_DATA : mem_rdata;
            end
          end
          state <= S_IDLE;
        end
        S_DUMP: begin
          dump_done <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // New work overrides the return to IDLE when there is a request.
      if (take_dump) begin
        state      <= S_DUMP;
        mem_fwrite <= 1'b1;
      end else if (take1) begin
        state     <= S_ACCESS;
        gnt1      <= 1'b1;
        cur_port  <= 1'b1;
        cur_we    <= we1;
        cur_oor   <= oor1;
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
        mem_read  <= !we1 && !oor1;
        mem_write <= we1 && !oor1;
      end else if (take0) begin
        state     <= S_ACCESS;
        gnt0      <= 1'b1;
        cur_port  <= 1'b0;
        cur_we    <= 1'b0;
        cur_oor   <= oor0;
        mem_addr  <= addr0;
        mem_read  <= !oor0;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter.
// A behavioural mainmemory stands in for the real memory. Expected completions
// are queued as {err, data} at grant time and popped by a completion monitor.
module tb_mem_arbiter;

  localparam logic [31:0] DEPTH_W = 32'd101;
  localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        req0;
  logic [31:0] addr0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        done1;
  logic [31:0] rdata1;
  logic        err;
  logic        dump_req;
  logic        dump_done;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic        mem_fwrite;
  logic [31:0] mem_rdata;

  int compared   = 0;
  int mismatched = 0;

  logic [32:0] exp0_q[$];
  logic [32:0] exp1_q[$];
  logic [32:0] mon_e;

  logic [31:0] mem_m  [0:127];
  logic [31:0] shadow [0:127];
  logic        mem_init   = 1'b0;
  int          fwrite_cnt = 0;
  logic [31:0] rdata1_m;
  logic        rr_m;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .addr0      (addr0),
    .gnt0       (gnt0),
    .rvalid0    (rvalid0),
    .rdata0     (rdata0),
    .req1       (req1),
    .we1        (we1),
    .addr1      (addr1),
    .wdata1     (wdata1),
    .gnt1       (gnt1),
    .done1      (done1),
    .rdata1     (rdata1),
    .err        (err),
    .dump_req   (dump_req),
    .dump_done  (dump_done),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_fwrite (mem_fwrite),
    .mem_rdata  (mem_rdata)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input int i);
    return (i == 19) ? 32'd14 : (32'hA000_0000 + 32'(i * 3));
  endfunction

  // Behavioural mainmemory: strobes sampled at the rising edge, registered read data.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 128; i++) mem_m[i] <= init_val(i);
      mem_init <= 1'b1;
    end else begin
      if (mem_write && mem_addr < 32'd128) mem_m[mem_addr[6:0]] <= mem_wdata;
      if (mem_read && mem_addr < 32'd128) mem_rdata <= mem_m[mem_addr[6:0]];
    end
    if (mem_fwrite) fwrite_cnt <= fwrite_cnt + 1;
  end

  // ---------------- comparison helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic push_expected(input logic port, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic oor;
    oor = (addr >= DEPTH_W);
    if (!port) begin
      exp0_q.push_back({oor, oor ? ERRD : shadow[addr[6:0]]});
    end else if (we) begin
      if (!oor) shadow[addr[6:0]] = wdata;
      exp1_q.push_back({oor, rdata1_m});
    end else begin
      rdata1_m = oor ? ERRD : shadow[addr[6:0]];
      exp1_q.push_back({oor, rdata1_m});
    end
    rr_m = !port;
  endtask

  // Completion monitor: every rvalid0/done1 must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid0) begin
        if (exp0_q.size() == 0) begin
          check1("rvalid0_unexpected", rvalid0, 1'b0);
        end else begin
          mon_e = exp0_q.pop_front();
          check("rdata0", rdata0, mon_e[31:0]);
          check1("err0", err, mon_e[32]);
        end
      end
      if (done1) begin
        if (exp1_q.size() == 0) begin
          check1("done1_unexpected", done1, 1'b0);
        end else begin
          mon_e = exp1_q.pop_front();
          check("rdata1", rdata1, mon_e[31:0]);
          check1("err1", err, mon_e[32]);
        end
      end
      if (err && !rvalid0 && !done1) check1("err_stray", err, 1'b0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_access(input logic port, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    logic oor;
    logic got;
    oor = (addr >= DEPTH_W);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = 1'b1; addr0 = addr;
    end
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = port ? gnt1 : gnt0;
    end
    check1("gnt_seen", got, 1'b1);
    if (got) begin
      push_expected(port, we, addr, wdata);
      check1("strobe_rd", mem_read, !we && !oor);
      check1("strobe_wr", mem_write, we && !oor);
      check("mem_addr", mem_addr, addr);
      if (we) check("mem_wdata", mem_wdata, wdata);
    end
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
    @(negedge clk);
    check1("done_early", port ? done1 : rvalid0, 1'b0);
    @(negedge clk);
    check1("done_pulse", port ? done1 : rvalid0, 1'b1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic got;
    logic exp_p;
    logic [31:0] a;
    int   fbase;

    rst_n = 1'b0; req0 = 1'b0; addr0 = '0; req1 = 1'b0; we1 = 1'b0;
    addr1 = '0; wdata1 = '0; dump_req = 1'b0;
    rdata1_m = '0; rr_m = 1'b1;
    for (int i = 0; i < 128; i++) shadow[i] = init_val(i);
    repeat (3) @(negedge clk);

    // Reset state
    check1("rst_gnt0", gnt0, 1'b0);
    check1("rst_mem_read", mem_read, 1'b0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check1("rst_fwrite", mem_fwrite, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch read of address 19
    do_access(1'b0, 1'b0, 32'd19, 32'd0);

    // Back-to-back store then load on port 1 with req1 held
    req1 = 1'b1; we1 = 1'b1; addr1 = 32'd50; wdata1 = 32'd7;
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = gnt1;
    end
    check1("st_gnt", got, 1'b1);
    check1("st_mem_write", mem_write, 1'b1);
    check1("st_mem_read", mem_read, 1'b0);
    check("st_mem_wdata", mem_wdata, 32'd7);
    push_expected(1'b1, 1'b1, 32'd50, 32'd7);
    we1 = 1'b0;
    @(negedge clk);
    check1("st_done_early", done1, 1'b0);
    @(negedge clk);
    check1("st_done", done1, 1'b1);
    check1("ld_gnt_b2b", gnt1, 1'b1);
    check1("ld_mem_read", mem_read, 1'b1);
    push_expected(1'b1, 1'b0, 32'd50, 32'd0);
    req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check1("ld_done", done1, 1'b1);

    // Address boundaries
    do_access(1'b1, 1'b0, 32'd101, 32'd0);
    do_access(1'b0, 1'b0, 32'd100, 32'd0);
    do_access(1'b0, 1'b0, 32'd101, 32'd0);
    do_access(1'b1, 1'b1, 32'hFFFF_FFFF, 32'd5);
    do_access(1'b1, 1'b1, 32'd100, 32'h55);
    do_access(1'b1, 1'b0, 32'd100, 32'd0);

    // Both ports requesting continuously for four grants
    req0 = 1'b1; addr0 = 32'd19;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'd100;
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int n = 0; n < 8 && !got; n++) begin
        @(negedge clk);
        got = gnt0 | gnt1;
      end
      check1("arb_gnt_seen", got, 1'b1);
      if (got) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_p = rr_m;
`else
        exp_p = 1'b1;
`endif
        check1("arb_winner", gnt1, exp_p);
        a = gnt1 ? 32'd100 : 32'd19;
        check("arb_addr", mem_addr, a);
        push_expected(gnt1, 1'b0, a, 32'd0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) @(negedge clk);

    // Dump beats a simultaneous fetch; then needs dump_req low before re-dump
    fbase = fwrite_cnt;
    dump_req = 1'b1; req0 = 1'b1; addr0 = 32'd19;
    @(negedge clk);
    check1("dump_fwrite", mem_fwrite, 1'b1);
    check1("dump_no_gnt0", gnt0, 1'b0);
    @(negedge clk);
    check1("dump_done", dump_done, 1'b1);
    check1("dump_fwrite_1cyc", mem_fwrite, 1'b0);
    @(negedge clk);
    check1("gnt0_after_dump", gnt0, 1'b1);
    check1("gnt0_after_dump_rd", mem_read, 1'b1);
    if (gnt0) push_expected(1'b0, 1'b0, 32'd19, 32'd0);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    check("dump_held_no_redump", 32'(fwrite_cnt - fbase), 32'd1);
    dump_req = 1'b0;
    @(negedge clk);
    dump_req = 1'b1;
    @(negedge clk);
    check1("redump_fwrite", mem_fwrite, 1'b1);
    dump_req = 1'b0;
    repeat (3) @(negedge clk);
    check("redump_count", 32'(fwrite_cnt - fbase), 32'd2);

    // Reset during ACCESS: in-flight read dropped
    req0 = 1'b1; addr0 = 32'd19;
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(negedge clk);
      got = gnt0;
    end
    check1("rst_mid_gnt", got, 1'b1);
    req0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check1("rstm_gnt0", gnt0, 1'b0);
    check1("rstm_mem_read", mem_read, 1'b0);
    check("rstm_mem_addr", mem_addr, 32'd0);
    check("rstm_rdata0", rdata0, 32'd0);
    check("rstm_rdata1", rdata1, 32'd0);
    check1("rstm_rvalid0", rvalid0, 1'b0);
    rdata1_m = '0;
    rr_m = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    do_access(1'b0, 1'b0, 32'd19, 32'd0);

    // Randomized single accesses
    for (int k = 0; k < 12; k++) begin
      logic p;
      logic w;
      p = 1'($urandom_range(0, 1));
      w = p ? 1'($urandom_range(0, 1)) : 1'b0;
      do_access(p, w, 32'($urandom_range(0, 110)), $urandom);
    end

    repeat (4) @(negedge clk);
    check("exp0_drained", 32'(exp0_q.size()), 32'd0);
    check("exp1_drained", 32'(exp1_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
